// File: rtl/arcade_input_pkg.sv
// Shared types, joystick bit layout and PS/2 keymap for arcade_input_mapper.
// Latency: n/a (constants only). Backpressure: n/a.
package arcade_input_pkg;

    typedef enum logic [3:0] {
        F_UP, F_DOWN, F_LEFT, F_RIGHT,
        F_FIRE0, F_FIRE1, F_FIRE2, F_FIRE3, F_FIRE4, F_FIRE5, F_FIRE6, F_FIRE7,
        F_START, F_COIN
    } func_e;

    // ext_care=0 matches code[7:0] only, so both plain and E0-prefixed arrows hit.
    typedef struct packed {
        logic       ext_care;
        logic [8:0] code;
        logic [1:0] player;
        func_e      func;
    } keymap_entry_t;

    localparam int JOY_W     = 16;
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_FIRE0 = 4;

    localparam int KEYMAP_N = 21;

    localparam keymap_entry_t KEYMAP [KEYMAP_N] = '{
        '{1'b0, 9'h075, 2'd0, F_UP},
        '{1'b0, 9'h072, 2'd0, F_DOWN},
        '{1'b0, 9'h06B, 2'd0, F_LEFT},
        '{1'b0, 9'h074, 2'd0, F_RIGHT},
        '{1'b1, 9'h029, 2'd0, F_FIRE0},
        '{1'b1, 9'h014, 2'd0, F_FIRE0},
        '{1'b1, 9'h011, 2'd0, F_FIRE1},
        '{1'b1, 9'h012, 2'd0, F_FIRE2},
        '{1'b1, 9'h005, 2'd0, F_START},
        '{1'b1, 9'h016, 2'd0, F_START},
        '{1'b1, 9'h02E, 2'd0, F_COIN},
        '{1'b1, 9'h02D, 2'd1, F_UP},
        '{1'b1, 9'h02B, 2'd1, F_DOWN},
        '{1'b1, 9'h023, 2'd1, F_LEFT},
        '{1'b1, 9'h034, 2'd1, F_RIGHT},
        '{1'b1, 9'h01C, 2'd1, F_FIRE0},
        '{1'b1, 9'h015, 2'd1, F_FIRE1},
        '{1'b1, 9'h01D, 2'd1, F_FIRE2},
        '{1'b1, 9'h006, 2'd1, F_START},
        '{1'b1, 9'h01E, 2'd1, F_START},
        '{1'b1, 9'h036, 2'd1, F_COIN}
    };

    // Joystick-layout bit for a function; -1 when the fire button is not built.
    function automatic int func_bit(input func_e f, input int num_fire);
        int fire_idx;
        fire_idx = int'(f) - int'(F_FIRE0);
        case (f)
            F_UP:    func_bit = JOY_UP;
            F_DOWN:  func_bit = JOY_DOWN;
            F_LEFT:  func_bit = JOY_LEFT;
            F_RIGHT: func_bit = JOY_RIGHT;
            F_START: func_bit = JOY_FIRE0 + num_fire;
            F_COIN:  func_bit = JOY_FIRE0 + num_fire + 1;
            default: func_bit = (fire_idx < num_fire) ? JOY_FIRE0 + fire_idx : -1;
        endcase
    endfunction

endpackage

// File: rtl/coin_stretch.sv
// Holds a coin request high for at least COIN_PULSE_CYC cycles after each rising edge.
// Latency: 1 clk raw -> stretched. Backpressure: none; a new edge mid-pulse reloads the timer.
module coin_stretch #(
    parameter int unsigned COIN_PULSE_CYC = 4000000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw,
    output logic stretched
);

    if (COIN_PULSE_CYC == 0) begin : g_pass
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                stretched <= 1'b0;
            end else begin
                stretched <= raw;
            end
        end
    end else begin : g_cnt
        localparam int CW = $clog2(COIN_PULSE_CYC + 1);
        localparam logic [CW-1:0] LOAD = CW'(COIN_PULSE_CYC);

        logic [CW-1:0] cnt;
        logic          raw_q;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                cnt       <= '0;
                raw_q     <= 1'b0;
                stretched <= 1'b0;
            end else begin
                raw_q     <= raw;
                stretched <= raw | (cnt != '0);
                if (raw && !raw_q) begin
                    cnt <= LOAD;
                end else if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// PS/2 keymap + MiSTer joystick merge into registered per-player controls; ARCADE_INPUT_SOCD_EN enables SOCD cleaning.
// Latency: joystick -> outputs 1 clk, key event -> outputs 2 clk, key_hit 1 clk after the event.
// Backpressure: none; every input is sampled each cycle, ps2_key events are edge (toggle) detected.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS    = 2,
    parameter int          NUM_FIRE       = 1,
    parameter int unsigned COIN_PULSE_CYC = 4000000
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [10:0]                  ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]    joystick,
    input  logic                         joy_merge,
    input  logic                         kbd_clear,
    output logic [4*NUM_PLAYERS-1:0]     p_dir,
    output logic [NUM_FIRE*NUM_PLAYERS-1:0] p_fire,
    output logic [NUM_PLAYERS-1:0]       p_start,
    output logic [NUM_PLAYERS-1:0]       p_coin,
    output logic                         key_hit
);

    localparam int PW       = JOY_FIRE0 + NUM_FIRE + 2;
    localparam int START_B  = JOY_FIRE0 + NUM_FIRE;
    localparam int COIN_B   = JOY_FIRE0 + NUM_FIRE + 1;

    logic [NUM_PLAYERS-1:0][PW-1:0] key_q;
    logic [NUM_PLAYERS-1:0][PW-1:0] key_nxt;
    logic [NUM_PLAYERS-1:0][PW-1:0] raw;
    logic [PW-1:0]                  joy_or;
    logic                           toggle_q;
    logic                           primed;
    logic                           evt;
    logic                           hit_nxt;
    logic                           unused_joy;

    logic [KEYMAP_N-1:0]                                ent_match;
    logic [KEYMAP_N-1:0][NUM_PLAYERS-1:0][PW-1:0]       ent_mask;

    assign unused_joy = ^joystick;

    // Per-entry decode: constant one-hot target mask plus a live code comparator.
    for (genvar e = 0; e < KEYMAP_N; e++) begin : g_map
        localparam int PL  = int'(KEYMAP[e].player);
        localparam int BIT = func_bit(KEYMAP[e].func, NUM_FIRE);

        if (KEYMAP[e].ext_care) begin : g_full
            assign ent_match[e] = (ps2_key[8:0] == KEYMAP[e].code);
        end else begin : g_code
            assign ent_match[e] = (ps2_key[7:0] == KEYMAP[e].code[7:0]);
        end

        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
            for (genvar b = 0; b < PW; b++) begin : g_bit
                localparam bit SEL = (p == PL) && (b == BIT);
                assign ent_mask[e][p][b] = SEL;
            end
        end
    end

    assign evt = primed && (ps2_key[10] != toggle_q);

    always_comb begin
        key_nxt = key_q;
        hit_nxt = 1'b0;
        for (int e = 0; e < KEYMAP_N; e++) begin
            if (evt && ent_match[e] && (|ent_mask[e])) begin
                hit_nxt = 1'b1;
                key_nxt = ps2_key[9] ? (key_nxt | ent_mask[e]) : (key_nxt & ~ent_mask[e]);
            end
        end
        if (kbd_clear) begin
            key_nxt = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
            primed   <= 1'b0;
            key_q    <= '0;
            key_hit  <= 1'b0;
        end else begin
            toggle_q <= ps2_key[10];
            primed   <= 1'b1;
            key_q    <= key_nxt;
            key_hit  <= hit_nxt;
        end
    end

    always_comb begin
        joy_or = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            joy_or = joy_or | joystick[16*p +: PW];
        end
    end

    always_comb begin
        raw = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            raw[p] = key_q[p] | (joy_merge ? joy_or : joystick[16*p +: PW]);
`ifdef ARCADE_INPUT_SOCD_EN
            if (raw[p][JOY_UP] && raw[p][JOY_DOWN]) begin
                raw[p][JOY_UP]   = 1'b0;
                raw[p][JOY_DOWN] = 1'b0;
            end
            if (raw[p][JOY_LEFT] && raw[p][JOY_RIGHT]) begin
                raw[p][JOY_LEFT]  = 1'b0;
                raw[p][JOY_RIGHT] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p_dir   <= '0;
            p_fire  <= '0;
            p_start <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                p_dir[4*p +: 4] <= {raw[p][JOY_UP], raw[p][JOY_DOWN],
                                    raw[p][JOY_LEFT], raw[p][JOY_RIGHT]};
                p_fire[NUM_FIRE*p +: NUM_FIRE] <= raw[p][JOY_FIRE0 +: NUM_FIRE];
                p_start[p] <= raw[p][START_B];
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        coin_stretch #(
            .COIN_PULSE_CYC (COIN_PULSE_CYC)
        ) u_coin_stretch (
            .clk_sys   (clk_sys),
            .reset_n   (reset_n),
            .raw       (raw[p][COIN_B]),
            .stretched (p_coin[p])
        );
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios plus random traffic against a keymap-level model.
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int NF = 3;
    localparam int C  = 10;
    localparam int B_R = 0, B_L = 1, B_D = 2, B_U = 3, B_F0 = 4;
    localparam int B_START = 4 + NF;
    localparam int B_COIN  = 5 + NF;
`ifdef ARCADE_INPUT_SOCD_EN
    localparam logic [3:0] SOCD_UD = 4'h0;
`else
    localparam logic [3:0] SOCD_UD = 4'hC;
`endif

    logic                 clk_sys = 1'b0;
    logic                 reset_n;
    logic [10:0]          ps2_key;
    logic [16*NP-1:0]     joystick;
    logic                 joy_merge;
    logic                 kbd_clear;
    logic [4*NP-1:0]      p_dir;
    logic [NF*NP-1:0]     p_fire;
    logic [NP-1:0]        p_start;
    logic [NP-1:0]        p_coin;
    logic                 key_hit;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    arcade_input_mapper #(
        .NUM_PLAYERS    (NP),
        .NUM_FIRE       (NF),
        .COIN_PULSE_CYC (C)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joystick  (joystick),
        .joy_merge (joy_merge),
        .kbd_clear (kbd_clear),
        .p_dir     (p_dir),
        .p_fire    (p_fire),
        .p_start   (p_start),
        .p_coin    (p_coin),
        .key_hit   (key_hit)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Keymap as a lookup: which player/control a 9-bit {ext,code} drives.
    function automatic bit lookup(input logic [8:0] k, output int pl, output int bt);
        lookup = 1'b1;
        pl = 0;
        bt = 0;
        case (k[7:0])
            8'h75:   bt = B_U;
            8'h72:   bt = B_D;
            8'h6B:   bt = B_L;
            8'h74:   bt = B_R;
            default: begin
                case (k)
                    9'h029, 9'h014: bt = B_F0;
                    9'h011: bt = B_F0 + 1;
                    9'h012: bt = B_F0 + 2;
                    9'h005, 9'h016: bt = B_START;
                    9'h02E: bt = B_COIN;
                    9'h02D: begin pl = 1; bt = B_U; end
                    9'h02B: begin pl = 1; bt = B_D; end
                    9'h023: begin pl = 1; bt = B_L; end
                    9'h034: begin pl = 1; bt = B_R; end
                    9'h01C: begin pl = 1; bt = B_F0; end
                    9'h015: begin pl = 1; bt = B_F0 + 1; end
                    9'h01D: begin pl = 1; bt = B_F0 + 2; end
                    9'h006, 9'h01E: begin pl = 1; bt = B_START; end
                    9'h036: begin pl = 1; bt = B_COIN; end
                    default: lookup = 1'b0;
                endcase
            end
        endcase
        if (pl >= NP) lookup = 1'b0;
    endfunction

    // Model state and expected outputs.
    bit           m_key [NP][16];
    bit           m_tog, m_primed;
    int           t_now = 0;
    int           last_edge [NP];
    bit           prev_coin [NP];
    logic [4*NP-1:0]  e_dir   = '0;
    logic [NF*NP-1:0] e_fire  = '0;
    logic [NP-1:0]    e_start = '0;
    logic [NP-1:0]    e_coin  = '0;
    logic             e_hit   = 1'b0;
    logic [15:0]      m_jor, m_j, m_r;
    bit               m_ev, m_up, m_dn, m_lf, m_rt;
    int               m_pl, m_bt;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NP; p++) begin
                for (int b = 0; b < 16; b++) m_key[p][b] = 1'b0;
                last_edge[p] = -1000;
                prev_coin[p] = 1'b0;
            end
            m_tog = 1'b0; m_primed = 1'b0;
            e_dir = '0; e_fire = '0; e_start = '0; e_coin = '0; e_hit = 1'b0;
        end else begin
            t_now++;
            m_jor = joystick[15:0] | joystick[31:16];
            for (int p = 0; p < NP; p++) begin
                m_j = joy_merge ? m_jor : joystick[16*p +: 16];
                for (int b = 0; b < 16; b++) m_r[b] = m_key[p][b] | m_j[b];
                m_up = m_r[B_U]; m_dn = m_r[B_D]; m_lf = m_r[B_L]; m_rt = m_r[B_R];
`ifdef ARCADE_INPUT_SOCD_EN
                if (m_up && m_dn) begin m_up = 0; m_dn = 0; end
                if (m_lf && m_rt) begin m_lf = 0; m_rt = 0; end
`endif
                e_dir[4*p +: 4] = {m_up, m_dn, m_lf, m_rt};
                for (int f = 0; f < NF; f++) e_fire[NF*p + f] = m_r[B_F0 + f];
                e_start[p] = m_r[B_START];
                if (m_r[B_COIN] && !prev_coin[p]) last_edge[p] = t_now;
                prev_coin[p] = m_r[B_COIN];
                e_coin[p] = m_r[B_COIN] || ((t_now - last_edge[p]) <= C);
            end
            m_ev = m_primed && (ps2_key[10] != m_tog);
            m_tog = ps2_key[10];
            m_primed = 1'b1;
            e_hit = 1'b0;
            if (m_ev && lookup(ps2_key[8:0], m_pl, m_bt)) begin
                e_hit = 1'b1;
                m_key[m_pl][m_bt] = ps2_key[9];
            end
            if (kbd_clear) begin
                for (int p = 0; p < NP; p++)
                    for (int b = 0; b < 16; b++) m_key[p][b] = 1'b0;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("cyc_p_dir",   p_dir,   e_dir);
            chk("cyc_p_fire",  p_fire,  e_fire);
            chk("cyc_p_start", p_start, e_start);
            chk("cyc_p_coin",  p_coin,  e_coin);
            chk("cyc_key_hit", key_hit, e_hit);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic key_evt(input logic pressed, input logic [8:0] k);
        ps2_key = {~ps2_key[10], pressed, k};
    endtask

    logic [8:0] pool [28] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h174,
                              9'h029, 9'h014, 9'h011, 9'h012, 9'h005, 9'h016, 9'h02E, 9'h02D,
                              9'h02B, 9'h023, 9'h034, 9'h01C, 9'h015, 9'h01D, 9'h006, 9'h01E,
                              9'h036, 9'h129, 9'h01A, 9'h12E};

    initial begin
        int cnt;
        logic [8:0] k;
        reset_n = 1'b1; ps2_key = 11'h400; joystick = '0; joy_merge = 1'b0; kbd_clear = 1'b0;
        #3 reset_n = 1'b0;
        tick(2);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;

        // Toggle bit already high at release must not look like an event.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_key_hit", key_hit, 1'b0);
            chk("rst_outputs", {p_dir, p_fire, p_start, p_coin}, '0);
        end

        key_evt(1'b1, 9'h175);
        tick(1);
        chk("up_hit", key_hit, 1'b1);
        chk("up_lat1", p_dir, 8'h00);
        tick(1);
        chk("up_set", p_dir, 8'h08);
        key_evt(1'b0, 9'h175);
        tick(2);
        chk("up_rel", p_dir, 8'h00);

        joy_merge = 1'b1; joystick = 32'h0001_0000;
        tick(1);
        chk("merge_on", p_dir, 8'h11);
        joy_merge = 1'b0;
        tick(1);
        chk("merge_off", p_dir, 8'h10);
        joystick = '0;
        tick(1);

        joystick[B_COIN] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (i == 0) joystick = '0;
            cnt += int'(p_coin[0]);
        end
        chk("coin_single", cnt, 11);

        joystick[B_COIN] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (i == 0) joystick = '0;
            if (i == 4) joystick[B_COIN] = 1'b1;
            if (i == 5) joystick = '0;
            cnt += int'(p_coin[0]);
        end
        chk("coin_reload", cnt, 16);

        key_evt(1'b1, 9'h01E);
        tick(2);
        chk("start_p2", p_start, 2'b10);
        key_evt(1'b1, 9'h016);
        tick(2);
        chk("start_both", p_start, 2'b11);

        joystick = 32'h0000_000C;
        tick(1);
        chk("socd_ud", p_dir[3:0], SOCD_UD);
        joystick = '0;

        key_evt(1'b1, 9'h075);
        tick(2);
        chk("held_up", p_dir, 8'h08);
        kbd_clear = 1'b1;
        tick(1);
        kbd_clear = 1'b0;
        tick(1);
        chk("clear_dir", p_dir, 8'h00);
        chk("clear_start", p_start, 2'b00);

        key_evt(1'b1, 9'h075);
        kbd_clear = 1'b1;
        tick(1);
        kbd_clear = 1'b0;
        chk("clear_evt_hit", key_hit, 1'b1);
        tick(1);
        chk("clear_evt_dir", p_dir, 8'h00);

        joystick[B_COIN] = 1'b1;
        tick(1);
        joystick = '0;
        tick(2);
        chk("coin_mid", p_coin[0], 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("coin_async_rst", p_coin, 2'b00);
        tick(1);
        #2 reset_n = 1'b1;
        tick(1);

        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if ($urandom_range(3) == 0) begin
                k = pool[$urandom_range(27)];
                key_evt(1'($urandom_range(1)), k);
            end
            kbd_clear = ($urandom_range(40) == 0);
            if ($urandom_range(50) == 0) joy_merge = ~joy_merge;
            if ($urandom_range(3) == 0) joystick = $urandom & $urandom & $urandom;
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                tick(1);
                #2 reset_n = 1'b1;
            end
        end

        tick(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
